sdram_port_arbiter: RTL and testbench

- Shares the single 16-bit RAM port between two requesters:
  - the SD-card loader, a write-only requester using a level `we` held until `op_begun`;
  - the audio playback reader, a read-only requester using a `req`/`ack`/`valid` protocol.
- Playback has priority because it is real-time. A burst limit stops the loader from starving.
- Exactly one RAM transaction is outstanding at a time.
- Sits between the loader/playback blocks and the RAM controller.

---
 rtl/sdram_port_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// ----------------------------------------------------------------------------
// sdram_port_arbiter
//
// Shares one 16-bit RAM controller port between the SD-card loader (write
// only, level request held until acknowledged) and the audio playback reader
// (read only, req/ack followed by a pb_valid data pulse). Playback has
// priority, but after PB_BURST_MAX back-to-back playback grants a waiting
// loader wins the next arbitration slot. Only one RAM transaction is in
// flight at a time. A read that never returns data within RD_TIMEOUT cycles
// parks the arbiter in a sticky error state that only reset can clear.
//
// Ports
//   clk50, reset_n          clock, asynchronous active-low reset
//   ld_we / ld_address / ld_data / ld_op_begun / ld_done
//                           loader request, acknowledge and image-done level
//   pb_req / pb_address / pb_ack / pb_rdata / pb_valid
//                           playback request, acknowledge and returned data
//   mem_req / mem_we / mem_address / mem_wdata
//                           transaction presented to the RAM controller
//   mem_op_begun / mem_rdata / mem_rdata_valid
//                           RAM controller accept and read-data return
//   arb_error               sticky read-timeout indication
// ----------------------------------------------------------------------------
module sdram_port_arbiter #(
  parameter int ADDR_W        = 25,
  parameter int DATA_W        = 16,
  parameter int PB_BURST_MAX  = 4,
  parameter int RD_TIMEOUT    = 1023,
  parameter int PB_AFTER_LOAD = 1
) (
  input  logic              clk50,
  input  logic              reset_n,
  // loader
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_address,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_op_begun,
  input  logic              ld_done,
  // playback
  input  logic              pb_req,
  input  logic [ADDR_W-1:0] pb_address,
  output logic              pb_ack,
  output logic [DATA_W-1:0] pb_rdata,
  output logic              pb_valid,
  // RAM controller
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_op_begun,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rdata_valid,
  // status
  output logic              arb_error
);

  localparam int RUN_W = (PB_BURST_MAX < 1) ? 1 : $clog2(PB_BURST_MAX + 1);
  localparam int TO_W  = (RD_TIMEOUT < 1) ? 1 : $clog2(RD_TIMEOUT + 1);

  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(PB_BURST_MAX);
  localparam logic [TO_W-1:0]  TO_LOAD = TO_W'(RD_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GRANT_LD = 3'd1,
    S_GRANT_PB = 3'd2,
    S_WAIT_RD  = 3'd3,
    S_ERROR    = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [RUN_W-1:0]    pb_run_q, pb_run_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic                load_seen_q, load_seen_d;
  logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                mem_we_q, mem_we_d;
  logic [DATA_W-1:0]   pb_rdata_q, pb_rdata_d;
  logic                pb_valid_q, pb_valid_d;
  logic                pb_eligible;

  // Playback is held off until the loader has finished the image at least
  // once, so playback never reads a half-written buffer.
  assign pb_eligible = pb_req && (load_seen_q || (PB_AFTER_LOAD == 0));

  always_comb begin
    state_d       = state_q;
    pb_run_d      = pb_run_q;
    to_cnt_d      = to_cnt_q;
    load_seen_d   = load_seen_q | ld_done;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    mem_we_d      = mem_we_q;
    pb_rdata_d    = pb_rdata_q;
    pb_valid_d    = 1'b0;
    mem_req       = 1'b0;
    ld_op_begun   = 1'b0;
    pb_ack        = 1'b0;
    arb_error     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Playback wins unless the loader is waiting and playback has
        // already used up its burst allowance.
        if (pb_eligible && (!ld_we || (pb_run_q < RUN_MAX))) begin
          state_d       = S_GRANT_PB;
          mem_address_d = pb_address;
          mem_we_d      = 1'b0;
          if (pb_run_q != RUN_MAX) begin
            pb_run_d = pb_run_q + RUN_W'(1);
          end
        end else if (ld_we) begin
          state_d       = S_GRANT_LD;
          mem_address_d = ld_address;
          mem_wdata_d   = ld_data;
          mem_we_d      = 1'b1;
          pb_run_d      = '0;
        end else begin
          pb_run_d = '0;
        end
      end

      S_GRANT_LD: begin
        mem_req     = 1'b1;
        ld_op_begun = mem_op_begun;
        if (mem_op_begun) begin
          state_d = S_IDLE;
        end
      end

      S_GRANT_PB: begin
        mem_req = 1'b1;
        pb_ack  = mem_op_begun;
        if (mem_op_begun) begin
          state_d  = S_WAIT_RD;
          to_cnt_d = TO_LOAD;
        end
      end

      S_WAIT_RD: begin
        to_cnt_d = (to_cnt_q == '0) ? '0 : to_cnt_q - TO_W'(1);
        // Data arriving on the very cycle the counter expires still wins.
        if (mem_rdata_valid) begin
          pb_rdata_d = mem_rdata;
          pb_valid_d = 1'b1;
          state_d    = S_IDLE;
        end else if (to_cnt_q <= TO_W'(1)) begin
          state_d = S_ERROR;
        end
      end

      S_ERROR: begin
        arb_error = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      pb_run_q      <= '0;
      to_cnt_q      <= '0;
      load_seen_q   <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      mem_we_q      <= 1'b0;
      pb_rdata_q    <= '0;
      pb_valid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pb_run_q      <= pb_run_d;
      to_cnt_q      <= to_cnt_d;
      load_seen_q   <= load_seen_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_we_q      <= mem_we_d;
      pb_rdata_q    <= pb_rdata_d;
      pb_valid_q    <= pb_valid_d;
    end
  end

  assign mem_address = mem_address_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_we      = mem_we_q;
  assign pb_rdata    = pb_rdata_q;
  assign pb_valid    = pb_valid_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_sdram_port_arbiter
//
// Directed bench for sdram_port_arbiter. Expected RAM transactions and
// expected read data are pushed to queues as stimulus is set up and popped
// when the arbiter presents a transaction or returns data.
// ----------------------------------------------------------------------------
module tb_sdram_port_arbiter;

  localparam int ADDR_W = 25;
  localparam int DATA_W = 16;

  logic              clk50;
  logic              reset_n;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_address;
  logic [DATA_W-1:0] ld_data;
  logic              ld_op_begun;
  logic              ld_done;
  logic              pb_req;
  logic [ADDR_W-1:0] pb_address;
  logic              pb_ack;
  logic [DATA_W-1:0] pb_rdata;
  logic              pb_valid;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_op_begun;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rdata_valid;
  logic              arb_error;

  sdram_port_arbiter #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .PB_BURST_MAX (4),
    .RD_TIMEOUT   (8),
    .PB_AFTER_LOAD(1)
  ) dut (
    .clk50          (clk50),
    .reset_n        (reset_n),
    .ld_we          (ld_we),
    .ld_address     (ld_address),
    .ld_data        (ld_data),
    .ld_op_begun    (ld_op_begun),
    .ld_done        (ld_done),
    .pb_req         (pb_req),
    .pb_address     (pb_address),
    .pb_ack         (pb_ack),
    .pb_rdata       (pb_rdata),
    .pb_valid       (pb_valid),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_address    (mem_address),
    .mem_wdata      (mem_wdata),
    .mem_op_begun   (mem_op_begun),
    .mem_rdata      (mem_rdata),
    .mem_rdata_valid(mem_rdata_valid),
    .arb_error      (arb_error)
  );

  initial clk50 = 1'b0;
  always #10 clk50 = ~clk50;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } txn_t;

  txn_t              exp_q[$];
  logic [DATA_W-1:0] rd_q[$];
  int                errors = 0;
  int                checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk50);
    #1;
  endtask

  task automatic push_txn(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    txn_t t;
    t.we = we;
    t.addr = a;
    t.data = d;
    exp_q.push_back(t);
  endtask

  // Wait for mem_req, check it against the scoreboard, then accept it one
  // cycle later. Returns in the drive slot just after the accepting edge.
  task automatic serve(input int budget);
    txn_t e;
    bit   got;
    int   n;
    got = 1'b0;
    n   = 0;
    while (!got && n < budget) begin
      @(negedge clk50);
      if (mem_req) got = 1'b1;
      n++;
    end
    chk("grant_seen", {31'd0, got}, 32'd1);
    if (!got) return;
    e = exp_q.pop_front();
    chk("mem_we", {31'd0, mem_we}, {31'd0, e.we});
    chk("mem_address", {7'd0, mem_address}, {7'd0, e.addr});
    if (e.we) chk("mem_wdata", {16'd0, mem_wdata}, {16'd0, e.data});
    chk("ack_early", {30'd0, ld_op_begun, pb_ack}, 32'd0);
    tick();
    mem_op_begun = 1'b1;
    @(negedge clk50);
    chk("ld_op_begun", {31'd0, ld_op_begun}, {31'd0, e.we});
    chk("pb_ack", {31'd0, pb_ack}, {31'd0, ~e.we});
    chk("addr_stable", {7'd0, mem_address}, {7'd0, e.addr});
    $display("txn we=%0d addr=0x%0h wdata=0x%0h", mem_we, mem_address, mem_wdata);
    tick();
    mem_op_begun = 1'b0;
  endtask

  // Return read data 'delay' cycles after the accepting edge (1 = first
  // WAIT_RD cycle) and check the single pb_valid pulse.
  task automatic rd_return(input int delay);
    logic [DATA_W-1:0] d;
    d = rd_q.pop_front();
    for (int i = 1; i < delay; i++) begin
      @(negedge clk50);
      chk("pb_valid_wait", {31'd0, pb_valid}, 32'd0);
      tick();
    end
    mem_rdata       = d;
    mem_rdata_valid = 1'b1;
    @(negedge clk50);
    chk("err_before_data", {31'd0, arb_error}, 32'd0);
    tick();
    mem_rdata_valid = 1'b0;
    mem_rdata       = 16'hDEAD;
    @(negedge clk50);
    chk("pb_valid", {31'd0, pb_valid}, 32'd1);
    chk("pb_rdata", {16'd0, pb_rdata}, {16'd0, d});
    $display("read data=0x%0h", pb_rdata);
    tick();
    @(negedge clk50);
    chk("pb_valid_drop", {31'd0, pb_valid}, 32'd0);
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ctl"}, {25'd0, mem_req, mem_we, pb_valid, arb_error, pb_ack, ld_op_begun, 1'b0}, 32'd0);
    chk({tag, "_addr"}, {7'd0, mem_address}, 32'd0);
    chk({tag, "_wdata"}, {16'd0, mem_wdata}, 32'd0);
    chk({tag, "_rdata"}, {16'd0, pb_rdata}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    reset_n = 1'b0; ld_we = 1'b0; ld_address = '0; ld_data = '0; ld_done = 1'b0;
    pb_req = 1'b0; pb_address = '0; mem_op_begun = 1'b0; mem_rdata = '0;
    mem_rdata_valid = 1'b0;
    #5;
    check_all_zero("reset");
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (2) tick();

    // Loader only
    push_txn(1'b1, 25'h10, 16'hBEEF);
    ld_we = 1'b1; ld_address = 25'h10; ld_data = 16'hBEEF;
    serve(5);
    ld_we = 1'b0;
    @(negedge clk50);
    chk("ld_single_pulse", {30'd0, ld_op_begun, mem_req}, 32'd0);
    tick();

    // Stray op_begun / rdata_valid in IDLE are ignored
    mem_op_begun = 1'b1; mem_rdata_valid = 1'b1; mem_rdata = 16'h5555;
    @(negedge clk50);
    chk("idle_stray_ack", {30'd0, ld_op_begun, pb_ack}, 32'd0);
    tick();
    mem_op_begun = 1'b0; mem_rdata_valid = 1'b0;
    @(negedge clk50);
    chk("idle_stray_valid", {30'd0, pb_valid, mem_req}, 32'd0);
    tick();

    // Playback gated until ld_done has been seen
    pb_req = 1'b1; pb_address = 25'h200;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk50);
      if (mem_req || pb_ack) cnt++;
      tick();
    end
    chk("gated_no_grant", cnt, 32'd0);
    ld_done = 1'b1;
    tick();
    ld_done = 1'b0;
    push_txn(1'b0, 25'h200, '0);
    rd_q.push_back(16'h1234);
    serve(2);
    pb_req = 1'b0;
    rd_return(3);

    // Contention: PB x4, LD, PB x4, LD
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) push_txn(1'b0, 25'h400, '0);
      push_txn(1'b1, 25'h20, 16'hC0DE);
    end
    ld_we = 1'b1; ld_address = 25'h20; ld_data = 16'hC0DE;
    pb_req = 1'b1; pb_address = 25'h400;
    for (int k = 0; k < 10; k++) begin
      if ((k % 5) != 4) rd_q.push_back(16'h1000 + 16'(k));
      serve(6);
      if (k == 9) begin
        ld_we = 1'b0; pb_req = 1'b0;
      end
      if ((k % 5) != 4) rd_return(1);
    end
    @(negedge clk50);
    chk("contention_idle", {31'd0, mem_req}, 32'd0);
    tick();

    // Asynchronous reset during GRANT_PB
    pb_req = 1'b1; pb_address = 25'h123;
    cnt = 0;
    while (!mem_req && cnt < 5) begin
      @(negedge clk50);
      cnt++;
    end
    chk("pb_grant_before_reset", {31'd0, mem_req}, 32'd1);
    #2;
    mem_op_begun = 1'b1;
    reset_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    tick();
    tick();
    reset_n = 1'b1; mem_op_begun = 1'b0;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk50);
      if (mem_req || pb_ack || pb_valid) cnt++;
      tick();
    end
    chk("post_reset_idle", cnt, 32'd0);
    pb_req = 1'b0;

    // Timeout race: data on the counter-zero cycle wins
    ld_done = 1'b1;
    tick();
    ld_done = 1'b0;
    push_txn(1'b0, 25'h300, '0);
    rd_q.push_back(16'hA5A5);
    pb_req = 1'b1; pb_address = 25'h300;
    serve(5);
    pb_req = 1'b0;
    rd_return(8);
    @(negedge clk50);
    chk("race_no_error", {31'd0, arb_error}, 32'd0);
    tick();

    // Timeout: no data ever returned
    push_txn(1'b0, 25'h301, '0);
    pb_req = 1'b1; pb_address = 25'h301;
    serve(5);
    pb_req = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk50);
      chk("timeout_wait", {31'd0, arb_error}, 32'd0);
      tick();
    end
    @(negedge clk50);
    chk("timeout_error", {31'd0, arb_error}, 32'd1);
    $display("timeout arb_error=%0d", arb_error);
    tick();
    ld_we = 1'b1; pb_req = 1'b1; mem_op_begun = 1'b1; mem_rdata_valid = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk50);
      if (mem_req || pb_ack || ld_op_begun || pb_valid) cnt++;
      tick();
    end
    chk("error_no_grants", cnt, 32'd0);
    chk("error_sticky", {31'd0, arb_error}, 32'd1);
    ld_we = 1'b0; pb_req = 1'b0; mem_op_begun = 1'b0; mem_rdata_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("error_cleared", {31'd0, arb_error}, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
